pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller_pkg.sv | 8 +
 rtl/pipeline_controller_hazard_detect.sv | 38 +++
 rtl/pipeline_controller.sv | 89 ++++++++
 tb/tb_pipeline_controller.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_controller_pkg.sv
// pipeline_controller_pkg: shared FSM encoding, forward-select codes and register-address width default
package pipeline_controller_pkg;
  localparam int REG_W_DEF = 4;
  typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_ERROR} state_t;
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EXE = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// hazard_detect: RAW comparator between ID sources and EXE/MEM destinations
// ports: src1/src2/two_src (ID reads), exe_*/mem_* (producers), exe_mem_read (EXE is a load)
//        -> hazard, plus sel_src1/sel_src2 (0 regfile, 1 EXE, 2 MEM) when FORWARDING_EN is defined
module hazard_detect
  import pipeline_controller_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             exe_wb_en,
  input  logic             mem_wb_en,
  input  logic             exe_mem_read,
  output logic             hazard
`ifdef FORWARDING_EN
  ,
  output logic [1:0]       sel_src1,
  output logic [1:0]       sel_src2
`endif
);
  logic e1, e2, m1, m2, load_use;
  assign e1 = exe_wb_en && src1 == exe_dest;
  assign e2 = two_src && exe_wb_en && src2 == exe_dest;
  assign m1 = mem_wb_en && src1 == mem_dest;
  assign m2 = two_src && mem_wb_en && src2 == mem_dest;
  // a load in EXE cannot be forwarded in time, so it stalls in either build
  assign load_use = exe_mem_read && (e1 || e2);
`ifdef FORWARDING_EN
  assign hazard = load_use;
  assign sel_src1 = e1 ? FWD_EXE : m1 ? FWD_MEM : FWD_RF;
  assign sel_src2 = e2 ? FWD_EXE : m2 ? FWD_MEM : FWD_RF;
`else
  assign hazard = load_use || e1 || e2 || m1 || m2;
`endif
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/flush control with memory-wait FSM, timeout error and stall counter
// ports: clk, rst (active-low async); src1/src2/two_src, exe_*/mem_* dest+wb_en, exe_mem_read,
//        branch_taken, mem_req, mem_ready -> *_freeze, *_flush, hazard, mem_timeout, stall_cnt
//        and sel_src1/sel_src2 when FORWARDING_EN is defined
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             exe_wb_en,
  input  logic             mem_wb_en,
  input  logic             exe_mem_read,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             if_freeze,
  output logic             id_freeze,
  output logic             exe_freeze,
  output logic             mem_freeze,
  output logic             if_flush,
  output logic             id_flush,
  output logic             hazard,
  output logic             mem_timeout,
  output logic [15:0]      stall_cnt
`ifdef FORWARDING_EN
  ,
  output logic [1:0]       sel_src1,
  output logic [1:0]       sel_src2
`endif
);
  localparam int WW = MEM_TIMEOUT < 1 ? 1 : $clog2(MEM_TIMEOUT + 1);
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt;
  logic mem_stall, flush, bubble;
  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .src1        (src1),
    .src2        (src2),
    .two_src     (two_src),
    .exe_dest    (exe_dest),
    .mem_dest    (mem_dest),
    .exe_wb_en   (exe_wb_en),
    .mem_wb_en   (mem_wb_en),
    .exe_mem_read(exe_mem_read),
    .hazard      (hazard)
`ifdef FORWARDING_EN
    ,
    .sel_src1    (sel_src1),
    .sel_src2    (sel_src2)
`endif
  );
  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:      state_nx = mem_req && !mem_ready ? ST_MEM_WAIT : ST_RUN;
      ST_MEM_WAIT: state_nx = mem_ready ? ST_RUN : wait_cnt == WW'(MEM_TIMEOUT) ? ST_ERROR : ST_MEM_WAIT;
      default:     state_nx = ST_ERROR;
    endcase
  end
  // the mem_ready cycle of MEM_WAIT already follows the RUN rules
  assign mem_stall   = state == ST_ERROR || ((state == ST_MEM_WAIT || mem_req) && !mem_ready);
  assign flush       = !mem_stall && branch_taken;
  assign bubble      = !mem_stall && !branch_taken && hazard;
  assign if_freeze   = mem_stall || bubble;
  assign id_freeze   = mem_stall;
  assign exe_freeze  = mem_stall;
  assign mem_freeze  = mem_stall;
  assign if_flush    = flush;
  assign id_flush    = flush || bubble;
  assign mem_timeout = state == ST_ERROR;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= state == ST_MEM_WAIT ? wait_cnt + WW'(1) : '0;
      if (if_freeze && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed vectors checked against a cycle model plus literal expectations
module tb_pipeline_controller;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] src1, src2, exe_dest, mem_dest;
  logic two_src, exe_wb_en, mem_wb_en, exe_mem_read, branch_taken, mem_req, mem_ready;
  logic if_freeze, id_freeze, exe_freeze, mem_freeze, if_flush, id_flush, hazard, mem_timeout;
  logic [15:0] stall_cnt;
`ifdef FORWARDING_EN
  logic [1:0] sel_src1, sel_src2;
`endif
  int errors = 0;
  int checks = 0;
  bit m_wait, m_err, m_stall, m_br, m_bub, m_haz;
  int m_waited, m_stalls;
  always #5 clk = ~clk;
  pipeline_controller #(.REG_W(4), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
    .exe_mem_read(exe_mem_read), .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .if_freeze(if_freeze), .id_freeze(id_freeze), .exe_freeze(exe_freeze), .mem_freeze(mem_freeze),
    .if_flush(if_flush), .id_flush(id_flush), .hazard(hazard), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt)
`ifdef FORWARDING_EN
    , .sel_src1(sel_src1), .sel_src2(sel_src2)
`endif
  );
  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask
  function automatic bit reads(input logic [3:0] r);
    return r == src1 || (two_src && r == src2);
  endfunction
  function automatic int fsel(input logic [3:0] s, input bit valid);
    if (valid && exe_wb_en && s == exe_dest) return 1;
    if (valid && mem_wb_en && s == mem_dest) return 2;
    return 0;
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      m_wait = 0; m_err = 0; m_waited = 0; m_stalls = 0;
    end
`ifdef FORWARDING_EN
    m_haz = exe_mem_read && exe_wb_en && reads(exe_dest);
    chk("sel_src1", sel_src1, fsel(src1, 1'b1));
    chk("sel_src2", sel_src2, fsel(src2, two_src));
`else
    m_haz = (exe_wb_en && reads(exe_dest)) || (mem_wb_en && reads(mem_dest));
`endif
    m_stall = m_err || (!mem_ready && (m_wait || mem_req));
    m_br = !m_stall && branch_taken;
    m_bub = !m_stall && !branch_taken && m_haz;
    chk("hazard", hazard, m_haz);
    chk("if_freeze", if_freeze, m_stall || m_bub);
    chk("id_freeze", id_freeze, m_stall);
    chk("exe_freeze", exe_freeze, m_stall);
    chk("mem_freeze", mem_freeze, m_stall);
    chk("if_flush", if_flush, m_br);
    chk("id_flush", id_flush, m_br || m_bub);
    chk("mem_timeout", mem_timeout, m_err);
    chk("stall_cnt", stall_cnt, m_stalls);
    if (rst) begin
      if (m_stall || m_bub) m_stalls = m_stalls < 65535 ? m_stalls + 1 : 65535;
      if (m_wait && mem_ready) m_wait = 0;
      else if (m_wait && m_waited == TO) begin m_wait = 0; m_err = 1; end
      else if (m_wait) m_waited++;
      else if (!m_err && mem_req && !mem_ready) begin m_wait = 1; m_waited = 0; end
    end
  end
  task automatic step(); @(posedge clk); #1; endtask
  task automatic look(); @(negedge clk); #1; endtask
  task automatic idle();
    src1 = '0; src2 = '0; exe_dest = '0; mem_dest = '0;
    two_src = 0; exe_wb_en = 0; mem_wb_en = 0; exe_mem_read = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask
  task automatic pulse_rst(); step(); rst = 0; look(); step(); rst = 1; endtask
  initial begin
    idle();
    look();
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_mem_timeout", mem_timeout, 0);
    chk("rst_if_freeze", if_freeze, 0);
    step(); rst = 1;
    src1 = 3; exe_dest = 3; exe_wb_en = 1;
    look();
`ifdef FORWARDING_EN
    chk("raw_exe_hazard", hazard, 0);
    chk("raw_exe_sel1", sel_src1, 1);
`else
    chk("raw_exe_hazard", hazard, 1);
    chk("raw_exe_if_freeze", if_freeze, 1);
    chk("raw_exe_id_flush", id_flush, 1);
`endif
    step(); idle();
    exe_mem_read = 1; exe_dest = 5; exe_wb_en = 1; src2 = 5; two_src = 1;
    look(); chk("load_use_hazard", hazard, 1); chk("load_use_id_flush", id_flush, 1);
    step(); two_src = 0;
    look(); chk("load_use_no_src2", hazard, 0);
    step(); idle();
    src1 = 7; mem_dest = 7; mem_wb_en = 1;
    look();
`ifdef FORWARDING_EN
    chk("mem_match_hazard", hazard, 0); chk("mem_match_sel1", sel_src1, 2);
`else
    chk("mem_match_hazard", hazard, 1);
`endif
    step(); exe_dest = 7; exe_wb_en = 1;
    look();
`ifdef FORWARDING_EN
    chk("exe_priority_sel1", sel_src1, 1);
`else
    chk("both_match_hazard", hazard, 1);
`endif
    step(); exe_wb_en = 0; mem_wb_en = 0;
    look(); chk("no_wb_hazard", hazard, 0);
    step(); idle();
    pulse_rst(); mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      look(); chk("wait_if_freeze", if_freeze, 1); chk("wait_mem_freeze", mem_freeze, 1);
      step();
    end
    mem_ready = 1;
    look(); chk("ready_if_freeze", if_freeze, 0);
    step(); idle();
    look(); chk("stall_cnt_4", stall_cnt, 4);
    step();
    src1 = 3; exe_dest = 3; exe_wb_en = 1; exe_mem_read = 1; branch_taken = 1;
    look(); chk("br_hazard", hazard, 1); chk("br_if_flush", if_flush, 1);
    chk("br_id_flush", id_flush, 1); chk("br_if_freeze", if_freeze, 0);
    step(); mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      look(); chk("br_stall_if_flush", if_flush, 0); chk("br_stall_if_freeze", if_freeze, 1);
      step();
    end
    mem_ready = 1;
    look(); chk("br_ready_if_flush", if_flush, 1); chk("br_ready_id_flush", id_flush, 1);
    step(); idle();
    mem_req = 1;
    step(); step(); step();
    mem_req = 0; rst = 0;
    look(); chk("midwait_rst_freeze", if_freeze, 0); chk("midwait_rst_cnt", stall_cnt, 0);
    step(); rst = 1;
    mem_req = 1;
    for (int i = 0; i < 10; i++) begin
      look(); chk("pre_timeout", mem_timeout, 0);
      step();
    end
    look(); chk("timeout_set", mem_timeout, 1); chk("timeout_exe_freeze", exe_freeze, 1);
    step(); mem_req = 0; mem_ready = 1;
    look(); chk("timeout_sticky", mem_timeout, 1); chk("timeout_freeze_held", if_freeze, 1);
    step(); rst = 0;
    look(); chk("timeout_rst_clear", mem_timeout, 0); chk("timeout_rst_freeze", if_freeze, 0);
    step(); rst = 1; idle();
    look(); chk("after_rst_run", mem_timeout, 0);
    step(); mem_req = 1;
    repeat (65560) step();
    look(); chk("stall_cnt_sat", stall_cnt, 16'hFFFF);
    step();
    look(); chk("stall_cnt_sat_hold", stall_cnt, 16'hFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
